pnu_tick_sched: RTL and testbench

Shared clock-divider scheduler. Up to NREQ requesters each ask for a burst of divided-clock ticks, each with its own divisor and tick count. The block grants the single internal divider to one requester at a time in round-robin order, runs the burst, and reports completion. It sits between the control FSMs of the term-project datapath and the slow-clock consumers (display scan, debounce, buzzer), replacing per-consumer free-running dividers.

---
 rtl/pnu_sched_pkg.sv | 14 +
 rtl/pnu_rr_arb.sv | 31 +++
 rtl/pnu_tick_sched.sv | 185 ++++++++++++++++++
 tb/tb_pnu_tick_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pnu_sched_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding and default widths.
package pnu_sched_pkg;

  localparam int unsigned DIV_W = 20;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/pnu_rr_arb.sv
// Combinational round-robin picker: the first requester after 'last' wins.
module pnu_rr_arb #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  win
);

  logic found;

  // Search indices above 'last' first, then wrap around to 0..last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) > last)) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) <= last)) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pnu_tick_sched.sv
// Shared clock-divider scheduler: grants one divider to requesters in round-robin
// order and runs a burst of divided-clock ticks for the winner.
// Optional feature macro: PNU_SCHED_ABORT_EN (dropping req mid-burst aborts it).
module pnu_tick_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DIV_W = pnu_sched_pkg::DIV_W,
  parameter int unsigned CNT_W = pnu_sched_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DIV_W-1:0]   div_val,
  input  logic [NREQ*CNT_W-1:0]   tick_cnt,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    tick,
  output logic                    div_clk,
  output logic [NREQ-1:0]         done
);

  import pnu_sched_pkg::*;

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef PNU_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               div_clk_q, div_clk_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [DIV_W-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [DIV_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]   c_q, c_d;

  logic [NREQ-1:0]    win;
  logic [IDX_W-1:0]   win_idx;
  logic [DIV_W-1:0]   sel_div;
  logic [CNT_W-1:0]   sel_cnt;
  logic [DIV_W-1:0]   p_inc;
  logic [CNT_W-1:0]   c_inc;

  pnu_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req  (req),
    .last (rr_q),
    .win  (win)
  );

  // Encode the one-hot winner and select the granted requester's parameters.
  always_comb begin
    win_idx = '0;
    sel_div = '0;
    sel_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = IDX_W'(i);
      if (gidx_q == IDX_W'(i)) begin
        sel_div = div_val[i*DIV_W +: DIV_W];
        sel_cnt = tick_cnt[i*CNT_W +: CNT_W];
      end
    end
  end

  assign p_inc = p_q + DIV_W'(1);
  assign c_inc = c_q + CNT_W'(1);

  // Next-state and next-output logic for the grant/burst FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    busy_d    = busy_q;
    tick_d    = 1'b0;
    div_clk_d = 1'b0;
    rr_d      = rr_q;
    gidx_d    = gidx_q;
    d_d       = d_q;
    n_d       = n_q;
    p_d       = p_q;
    c_d       = c_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = win;
          gidx_d  = win_idx;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        d_d = (sel_div == '0) ? DIV_W'(1) : sel_div;
        n_d = sel_cnt;
        p_d = '0;
        c_d = '0;
        if (sel_cnt == '0) begin
          state_d = S_DONE;
          done_d  = gnt_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (p_q == d_q - DIV_W'(1)) begin
          p_d    = '0;
          c_d    = c_inc;
          tick_d = 1'b1;
          if (c_inc == n_q) begin
            state_d = S_DONE;
            done_d  = gnt_q;
          end
        end else begin
          p_d       = p_inc;
          div_clk_d = (d_q > DIV_W'(1)) && (p_inc >= (d_q >> 1));
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        rr_d    = gidx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Granted requester withdrew mid-burst: drop straight back to idle.
    if (ABORT_EN && ((state_q == S_LOAD) || (state_q == S_RUN)) && ((req & gnt_q) == '0)) begin
      state_d   = S_IDLE;
      gnt_d     = '0;
      done_d    = '0;
      busy_d    = 1'b0;
      tick_d    = 1'b0;
      div_clk_d = 1'b0;
      rr_d      = gidx_q;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      div_clk_q <= 1'b0;
      rr_q      <= IDX_W'(NREQ - 1);
      gidx_q    <= '0;
      d_q       <= '0;
      n_q       <= '0;
      p_q       <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      div_clk_q <= div_clk_d;
      rr_q      <= rr_d;
      gidx_q    <= gidx_d;
      d_q       <= d_d;
      n_q       <= n_d;
      p_q       <= p_d;
      c_q       <= c_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign tick    = tick_q;
  assign div_clk = div_clk_q;

endmodule

// File: tb/tb_pnu_tick_sched.sv
// Self-checking bench for pnu_tick_sched; expected waveforms are derived per cycle
// from burst arithmetic (N*D RUN cycles, tick every D) and a round-robin pointer model.
module tb_pnu_tick_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DIV_W = 20;
  localparam int unsigned CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] div_val;
  logic [NREQ*CNT_W-1:0] tick_cnt;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  tick;
  logic                  div_clk;
  logic [NREQ-1:0]       done;

  int checks = 0;
  int errors = 0;
  int model_ptr;

  pnu_tick_sched #(
    .NREQ  (NREQ),
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .div_val  (div_val),
    .tick_cnt (tick_cnt),
    .gnt      (gnt),
    .busy     (busy),
    .tick     (tick),
    .div_clk  (div_clk),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Round-robin reference: first requesting index after ptr, wrapping.
  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Cycle index (0 = first granted cycle) of the done pulse.
  function automatic int done_t(input int dv, input int n);
    int d;
    d = (dv == 0) ? 1 : dv;
    return n * d + 1;
  endfunction

  task automatic set_params(input int i, input int dv, input int n);
    div_val[i*DIV_W +: DIV_W]  = DIV_W'(dv);
    tick_cnt[i*CNT_W +: CNT_W] = CNT_W'(n);
  endtask

  // Checks every output from the grant cycle through the following idle cycle.
  task automatic check_burst(input int g, input int dv, input int n, input int drop_t, input string name);
    int d;
    int last_t;
    logic [NREQ-1:0] oh;
    d = (dv == 0) ? 1 : dv;
    last_t = n * d + 1;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    for (int t = 0; t <= last_t + 1; t++) begin
      logic            in_b;
      logic            e_tick;
      logic            e_dclk;
      logic [NREQ-1:0] e_gnt;
      logic [NREQ-1:0] e_done;
      in_b   = (t <= last_t);
      e_gnt  = in_b ? oh : '0;
      e_done = (t == last_t) ? oh : '0;
      e_tick = (t >= d + 1) && (t <= last_t) && (((t - 1) % d) == 0);
      e_dclk = (t >= 1) && (t <= n * d) && (d > 1) && (((t - 1) % d) >= d / 2);
      @(negedge clk);
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL %s gnt t=%0d got %b expected %b", name, t, gnt, e_gnt);
      end
      checks++;
      if (busy !== in_b) begin
        errors++;
        $display("FAIL %s busy t=%0d got %b expected %b", name, t, busy, in_b);
      end
      checks++;
      if (tick !== e_tick) begin
        errors++;
        $display("FAIL %s tick t=%0d got %b expected %b", name, t, tick, e_tick);
      end
      checks++;
      if (div_clk !== e_dclk) begin
        errors++;
        $display("FAIL %s div_clk t=%0d got %b expected %b", name, t, div_clk, e_dclk);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL %s done t=%0d got %b expected %b", name, t, done, e_done);
      end
      if (t == drop_t && g >= 0) req[g] = 1'b0;
    end
    model_ptr = g;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    div_val = '0;
    tick_cnt = '0;
    #1;
    checks++;
    if ({gnt, busy, tick, div_clk, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected all zero", {gnt, busy, tick, div_clk, done});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, busy, tick, div_clk, done} !== '0) begin
      errors++;
      $display("FAIL reset_clocked got %b expected all zero", {gnt, busy, tick, div_clk, done});
    end
    rst = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  task automatic test_basic();
    int g;
    set_params(0, 4, 3);
    req = 4'b0001;
    g = pick(req, model_ptr);
    check_burst(g, 4, 3, done_t(4, 3), "basic");
  endtask

  task automatic test_round_robin();
    int g;
    set_params(0, 2, 1);
    set_params(2, 2, 1);
    req = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      g = pick(req, model_ptr);
      check_burst(g, 2, 1, -1, "round_robin");
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle busy got %b expected 0", busy);
    end
  endtask

  task automatic test_edges();
    int g;
    set_params(1, 0, 2);
    req = 4'b0010;
    g = pick(req, model_ptr);
    check_burst(g, 0, 2, done_t(0, 2), "div_zero");
    set_params(3, 5, 0);
    req = 4'b1000;
    g = pick(req, model_ptr);
    check_burst(g, 5, 0, done_t(5, 0), "cnt_zero");
  endtask

  task automatic test_input_stability();
    int g;
    set_params(0, 4, 3);
    req = 4'b0001;
    g = pick(req, model_ptr);
    fork
      check_burst(g, 4, 3, done_t(4, 3), "stability");
      begin
        repeat (4) @(negedge clk);
        set_params(0, 8, 7);
      end
    join
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] oh;
    set_params(2, 3, 6);
    req = 4'b0100;
`ifdef PNU_SCHED_ABORT_EN
    oh = 4'b0100;
    for (int t = 0; t <= 10; t++) begin
      logic            in_b;
      logic            e_tick;
      logic [NREQ-1:0] e_gnt;
      in_b   = (t <= 7);
      e_gnt  = in_b ? oh : '0;
      e_tick = (t == 4) || (t == 7);
      @(negedge clk);
      checks++;
      if (gnt !== e_gnt) begin
        errors++;
        $display("FAIL abort gnt t=%0d got %b expected %b", t, gnt, e_gnt);
      end
      checks++;
      if (busy !== in_b) begin
        errors++;
        $display("FAIL abort busy t=%0d got %b expected %b", t, busy, in_b);
      end
      checks++;
      if (tick !== e_tick) begin
        errors++;
        $display("FAIL abort tick t=%0d got %b expected %b", t, tick, e_tick);
      end
      checks++;
      if (done !== '0) begin
        errors++;
        $display("FAIL abort done t=%0d got %b expected 0000", t, done);
      end
      if (t >= 8) begin
        checks++;
        if (div_clk !== 1'b0) begin
          errors++;
          $display("FAIL abort div_clk t=%0d got %b expected 0", t, div_clk);
        end
      end
      if (t == 7) req[2] = 1'b0;
    end
    model_ptr = 2;
`else
    oh = '0;
    check_burst(pick(req, model_ptr) + int'(oh), 3, 6, 7, "no_abort");
`endif
  endtask

  task automatic test_reset_mid_run();
    int g;
    set_params(0, 10, 5);
    set_params(1, 3, 2);
    req = 4'b0001;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, busy, tick, div_clk, done} !== '0) begin
      errors++;
      $display("FAIL midrun_async got %b expected all zero", {gnt, busy, tick, div_clk, done});
    end
    @(negedge clk);
    req = 4'b0011;
    checks++;
    if ({gnt, busy, tick, div_clk, done} !== '0) begin
      errors++;
      $display("FAIL midrun_held got %b expected all zero", {gnt, busy, tick, div_clk, done});
    end
    rst = 1'b0;
    model_ptr = NREQ - 1;
    g = pick(req, model_ptr);
    check_burst(g, (g == 0) ? 10 : 3, (g == 0) ? 5 : 2, (g == 0) ? done_t(10, 5) : done_t(3, 2), "after_reset_a");
    g = pick(req, model_ptr);
    check_burst(g, (g == 0) ? 10 : 3, (g == 0) ? 5 : 2, (g == 0) ? done_t(10, 5) : done_t(3, 2), "after_reset_b");
    req = '0;
  endtask

  task automatic test_random();
    int dv [NREQ];
    int nv [NREQ];
    int g;
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        dv[i] = int'($urandom_range(0, 5));
        nv[i] = int'($urandom_range(0, 3));
        set_params(i, dv[i], nv[i]);
      end
      req = NREQ'($urandom_range(1, 15));
      for (int k = 0; k < NREQ && req != '0; k++) begin
        g = pick(req, model_ptr);
        check_burst(g, dv[g], nv[g], done_t(dv[g], nv[g]), "random");
      end
      req = '0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_edges();
    test_input_stability();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
